// File: rtl/mdclcg_pkg.sv
// Shared types and constants for the modified dual-CLCG generator and its controller.
package mdclcg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      WARMUP = 2'd2,
      RUN    = 2'd3
   } state_t;

   localparam int LOAD_CYCLES = 2;

   localparam int WORD_W_DEF = 16;
   localparam int MW_DEF     = 4;
   localparam int DISC_W_DEF = 8;

endpackage

// File: rtl/mdclcg_packer.sv
// Serial-to-parallel packer: collects z bits MSB-first into words and holds them
// on a valid/ready output, flagging words lost to back-pressure.
module mdclcg_packer #(
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              clr_status,
   input  logic              shift_en,
   input  logic              bit_in,
   input  logic              word_ready,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   output logic              overflow
);

   localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   logic [WORD_W-1:0] shift_reg;
   logic [WORD_W-1:0] shift_next;
   logic [CW-1:0]     bit_cnt_reg;
   logic [WORD_W-1:0] data_reg;
   logic              valid_reg;
   logic              overflow_reg;
   logic              complete;

   assign shift_next = {shift_reg[WORD_W-2:0], bit_in};
   assign complete   = shift_en && !flush && (bit_cnt_reg == CW'(WORD_W - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
      end else if (flush) begin
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
      end else if (shift_en) begin
         shift_reg   <= shift_next;
         bit_cnt_reg <= complete ? '0 : bit_cnt_reg + CW'(1);
      end
   end

   // A finished word may overwrite the held one only if that one leaves this same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_reg     <= '0;
         valid_reg    <= 1'b0;
         overflow_reg <= 1'b0;
      end else if (clr_status) begin
         valid_reg    <= 1'b0;
         overflow_reg <= 1'b0;
      end else if (complete) begin
         if (!valid_reg || word_ready) begin
            data_reg  <= shift_next;
            valid_reg <= 1'b1;
         end else begin
            overflow_reg <= 1'b1;
         end
      end else if (valid_reg && word_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign word_data  = data_reg;
   assign word_valid = valid_reg;
   assign overflow   = overflow_reg;

endmodule

// File: rtl/mdclcg_ctrl.sv
// Sequencer for the dual-CLCG datapath: holds config, resets/starts the datapath,
// drops warm-up bits and hands the z stream to the word packer.
module mdclcg_ctrl
   import mdclcg_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int MW     = MW_DEF,
   parameter int DISC_W = DISC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [WORD_W-1:0] cfg_a,
   input  logic [WORD_W-1:0] cfg_b,
   input  logic [WORD_W-1:0] cfg_seed,
   input  logic [MW-1:0]     cfg_m,
   input  logic [MW-1:0]     cfg_r,
   input  logic [DISC_W-1:0] cfg_discard,
   input  logic              cmd_start,
   input  logic              cmd_stop,
   output logic              busy,
   output logic              cfg_err,
   output logic              dp_rst,
   output logic              dp_start,
   output logic [WORD_W-1:0] dp_a,
   output logic [WORD_W-1:0] dp_b,
   output logic [WORD_W-1:0] dp_seed,
   output logic [MW-1:0]     dp_m,
   output logic [MW-1:0]     dp_r,
   input  logic              dp_z,
   input  logic              dp_z_vld,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              overflow
);

   state_t            state_reg, state_next;
   logic [WORD_W-1:0] a_reg, b_reg, seed_reg;
   logic [MW-1:0]     m_reg, r_reg;
   logic [DISC_W-1:0] discard_reg;
   logic [DISC_W-1:0] disc_cnt_reg;
   logic [1:0]        load_cnt_reg;
   logic              cfg_err_reg;
   logic              cfg_legal;
   logic              cfg_wr;
   logic              start_ok;
   logic              stop_ok;
   logic              shift_en;

   assign cfg_legal = (m_reg != '0) && (r_reg < m_reg);
   assign cfg_wr    = (state_reg == IDLE) && cfg_we;
   assign start_ok  = (state_reg == IDLE) && cmd_start && cfg_legal;
   assign stop_ok   = (state_reg != IDLE) && cmd_stop;
   assign shift_en  = (state_reg == RUN) && dp_z_vld;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_ok) state_next = LOAD;
         LOAD:    if (load_cnt_reg == 2'(LOAD_CYCLES - 1))
                     state_next = (discard_reg == '0) ? RUN : WARMUP;
         WARMUP:  if (dp_z_vld && disc_cnt_reg <= DISC_W'(1)) state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = IDLE;
      endcase
      if (stop_ok) state_next = IDLE;
   end

   always_comb begin
      busy     = (state_reg != IDLE);
      dp_rst   = (state_reg == LOAD);
      dp_start = (state_reg == WARMUP) || (state_reg == RUN);
   end

   // A refused start in the same cycle as a config write still flags the old config.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg        <= '0;
         b_reg        <= '0;
         seed_reg     <= '0;
         m_reg        <= '0;
         r_reg        <= '0;
         discard_reg  <= '0;
         cfg_err_reg  <= 1'b0;
         load_cnt_reg <= '0;
         disc_cnt_reg <= '0;
      end else begin
         if (cfg_wr) begin
            a_reg       <= cfg_a;
            b_reg       <= cfg_b;
            seed_reg    <= cfg_seed;
            m_reg       <= cfg_m;
            r_reg       <= cfg_r;
            discard_reg <= cfg_discard;
         end
         if ((state_reg == IDLE) && cmd_start && !cfg_legal) cfg_err_reg <= 1'b1;
         else if (cfg_wr)                                    cfg_err_reg <= 1'b0;
         load_cnt_reg <= (state_reg == LOAD) ? load_cnt_reg + 2'd1 : 2'd0;
         if (state_reg == LOAD)
            disc_cnt_reg <= discard_reg;
         else if ((state_reg == WARMUP) && dp_z_vld)
            disc_cnt_reg <= disc_cnt_reg - DISC_W'(1);
      end
   end

   assign cfg_err = cfg_err_reg;
   assign dp_a    = a_reg;
   assign dp_b    = b_reg;
   assign dp_seed = seed_reg;
   assign dp_m    = m_reg;
   assign dp_r    = r_reg;

   mdclcg_packer #(
      .WORD_W(WORD_W)
   ) u_packer (
      .clk       (clk),
      .rst       (rst),
      .flush     (start_ok | stop_ok),
      .clr_status(start_ok),
      .shift_en  (shift_en),
      .bit_in    (dp_z),
      .word_ready(word_ready),
      .word_data (word_data),
      .word_valid(word_valid),
      .overflow  (overflow)
   );

endmodule

// File: doc/mdclcg_ctrl.md
Name: mdclcg_ctrl

Overview:
Single-clock sequencer for the modified dual-CLCG datapath.
- Holds the generator configuration: a, b, m, r, seed.
- Resets and starts the datapath, then discards a programmable number of warm-up bits.
- Packs the serial z_i stream into WORD_W-bit words and presents them on a valid/ready interface.
- Sits between the host/config bus and the datapath; it is the only driver of the datapath's control and config inputs.

Parameters:
WORD_W, 16, width of assembled output word and of a/b/seed config.
MW, 4, width of m and r config fields.
DISC_W, 8, width of warm-up discard counter.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-low reset.
cfg_we  in  1  config write strobe; honoured only in IDLE.
cfg_a  in  WORD_W  multiplier a.
cfg_b  in  WORD_W  multiplier b.
cfg_seed  in  WORD_W  seed.
cfg_m  in  MW  modulus exponent m.
cfg_r  in  MW  shift r.
cfg_discard  in  DISC_W  warm-up bits to drop.
cmd_start  in  1  one-cycle start request.
cmd_stop  in  1  one-cycle stop request.
busy  out  1  high in any state except IDLE.
cfg_err  out  1  sticky: start refused due to illegal config; cleared by next accepted cfg_we.
dp_rst  out  1  active-high reset to datapath.
dp_start  out  1  level start to datapath.
dp_a, dp_b, dp_seed  out  WORD_W each  registered config to datapath.
dp_m, dp_r  out  MW each  registered config to datapath.
dp_z  in  1  datapath output bit.
dp_z_vld  in  1  strobe: dp_z is a new bit this cycle.
word_data  out  WORD_W  assembled word.
word_valid  out  1  word_data valid.
word_ready  in  1  consumer accepts when valid&ready.
overflow  out  1  sticky: word dropped; cleared by cmd_start.

Behaviour:
Reset (rst=0, asynchronous):
- State = IDLE.
- All outputs 0: busy, cfg_err, dp_rst, dp_start, dp_*, word_data, word_valid, overflow.
- Config registers 0; bit counter, discard counter and shift register 0.

States and transitions:
- IDLE: cfg_we loads all config registers; dp_* follow the registers combinationally.
  - cmd_start with legal config (m!=0, r<m): go to LOAD; clear overflow and word_valid.
  - cmd_start with illegal config: stay IDLE; set cfg_err.
- LOAD: dp_rst=1 for exactly 2 cycles, then go to WARMUP; discard counter = cfg_discard.
- WARMUP: dp_start=1. Each dp_z_vld decrements the discard counter; the bit is not stored.
  - Counter reaches 0: go to RUN.
  - cfg_discard=0: LOAD goes directly to RUN.
- RUN: dp_start=1. Each dp_z_vld shifts the register left with dp_z entering the LSB (first bit ends in MSB); bit counter +1.
  - On the edge sampling the WORD_W-th bit: word_data <= assembled word, word_valid <= 1, bit counter wraps to 0. word_valid is seen the cycle after the last bit (1-cycle latency).
- Handshake: word_valid stays high and word_data stays stable until valid&ready.
  - New word completes while word_valid=1 and word_ready=0: new word dropped, overflow <= 1, old word kept.
  - Completion in the same cycle as handshake acceptance: the new word replaces the old one; word_valid stays 1; no overflow.
- cmd_stop in LOAD/WARMUP/RUN: next state IDLE.
  - dp_start and dp_rst deassert next cycle; the partial word is discarded and the bit counter cleared.
  - A pending word_valid is retained until accepted.
- cmd_start outside IDLE is ignored. cmd_start and cmd_stop together in IDLE: start wins. Both together outside IDLE: stop wins.
- cfg_we outside IDLE is ignored; config never changes mid-run.
- dp_z_vld during LOAD is ignored.

Decomposition:
- Shared package mdclcg_pkg holds:
  - the state enum (IDLE, LOAD, WARMUP, RUN);
  - the constant LOAD_CYCLES=2;
  - the default WORD_W/MW values used by datapath and controller.
- Sub-module mdclcg_packer: shift register, bit counter, output register, valid/ready, and overflow logic. The FSM stays in mdclcg_ctrl.

Test Plan:
- Reset: assert rst=0 mid-RUN with word_valid=1 -> all outputs 0 within the same cycle; after release, state IDLE and busy=0.
- Normal run: cfg a=0x5555, b=0x1753, seed=0x3427, m=8, r=2, discard=4; cmd_start; feed 4 junk bits, then bits of 0xA5C3 MSB-first with word_ready=1 -> dp_rst high exactly 2 cycles; word_data=0xA5C3 with word_valid one cycle after the 16th bit; overflow=0.
- Back-pressure: word_ready=0; feed two full words 0x1234 then 0xFFFF -> word_data stays 0x1234; overflow=1; after ready, 0x1234 accepted once and word_valid drops.
- Simultaneous: the last bit of 0x00FF arrives in the same cycle as acceptance of 0x1234 -> word_valid stays 1; word_data=0x00FF; overflow=0.
- Stop mid-word: after 7 bits of RUN, cmd_stop -> IDLE next cycle; dp_start=0; a restart with a new word yields the correct first word (no stale bits).
- Config guard: m=0, cmd_start -> cfg_err=1, busy=0. cfg_we during RUN with a=0 -> dp_a unchanged. A valid cfg_we in IDLE clears cfg_err.
